// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg
//   Shared types and helpers for the multi-channel microsecond delay timer.
//   state_t   : per-channel run state (IDLE / RUN).
//   pre_width : width of the per-channel prescaler for a given clock in MHz,
//               never less than one bit, so a 1 MHz clock still gets a register.
package delay_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int pre_width(input int mhz);
    return (mhz < 2) ? 1 : $clog2(mhz);
  endfunction

endpackage

// File: rtl/delay_timer_channel.sv
// delay_timer_channel
//   One independent microsecond timer: a cycle-exact prescaler that divides the
//   clock down to 1 us, a microsecond down-counter, and the delay/mode latched
//   on start so later input changes do not disturb a running timer.
//
// Ports
//   CLK       in  1            rising-edge clock
//   RST_N     in  1            asynchronous active-low reset
//   start     in  1            start / retrigger request (level-sampled)
//   cancel    in  1            stop request, wins over start
//   periodic  in  1            mode latched on start: 0 one-shot, 1 periodic
//   delay_us  in  DELAY_WIDTH  delay in microseconds latched on start
//   busy      out 1            channel is counting (registered)
//   done      out 1            one-cycle expiry pulse (registered)
module delay_timer_channel
  import delay_timer_pkg::*;
#(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int DELAY_WIDTH     = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic                   cancel,
  input  logic                   periodic,
  input  logic [DELAY_WIDTH-1:0] delay_us,
  output logic                   busy,
  output logic                   done
);

  localparam int             PW      = pre_width(CLOCK_SPEED_MHZ);
  localparam logic [PW-1:0]  PRE_MAX = PW'(CLOCK_SPEED_MHZ - 1);

  state_t                 state;
  logic [PW-1:0]          pre;
  logic [DELAY_WIDTH-1:0] us_left;
  logic [DELAY_WIDTH-1:0] delay_lat;
  logic                   mode_lat;

  // busy comes straight from the state register, so it stays registered.
  assign busy = (state == RUN);

  // Priority per edge is cancel > start > count. A start or cancel landing on
  // the expiry edge swallows that expiry, because done is only set in the
  // counting branch. The expiry test (pre at its top, one us left) fires
  // before us_left could ever reach zero, so the counter never wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      pre       <= '0;
      us_left   <= '0;
      delay_lat <= '0;
      mode_lat  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        pre   <= '0;
      end else if (start) begin
        pre <= '0;
        if (delay_us != '0) begin
          delay_lat <= delay_us;
          mode_lat  <= periodic;
          us_left   <= delay_us;
          state     <= RUN;
        end else begin
          // A zero delay expires immediately and never enters RUN.
          done  <= 1'b1;
          state <= IDLE;
        end
      end else if (state == RUN) begin
        if (pre != PRE_MAX) begin
          pre <= pre + PW'(1);
        end else begin
          pre <= '0;
          if (us_left == DELAY_WIDTH'(1)) begin
            done <= 1'b1;
            if (mode_lat) begin
              us_left <= delay_lat;
            end else begin
              state <= IDLE;
            end
          end else begin
            us_left <= us_left - DELAY_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/delay_timer.sv
// delay_timer
//   Multi-channel microsecond delay timer. Each of CHANNELS timers runs on its
//   own prescaler, so expiry timing is cycle-exact relative to its own start
//   and does not depend on any shared tick phase.
//
// Ports
//   CLK       in  1                      rising-edge clock
//   RST_N     in  1                      asynchronous active-low reset
//   start     in  CHANNELS               per-channel start / retrigger
//   cancel    in  CHANNELS               per-channel stop
//   periodic  in  CHANNELS               per-channel mode, latched on start
//   delay_us  in  CHANNELS*DELAY_WIDTH   channel i at [i*DELAY_WIDTH +: DELAY_WIDTH]
//   busy      out CHANNELS               channel counting
//   done      out CHANNELS               one-cycle expiry pulses
module delay_timer #(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int CHANNELS        = 4,
  parameter int DELAY_WIDTH     = 16
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [CHANNELS-1:0]             start,
  input  logic [CHANNELS-1:0]             cancel,
  input  logic [CHANNELS-1:0]             periodic,
  input  logic [CHANNELS*DELAY_WIDTH-1:0] delay_us,
  output logic [CHANNELS-1:0]             busy,
  output logic [CHANNELS-1:0]             done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    delay_timer_channel #(
      .CLOCK_SPEED_MHZ (CLOCK_SPEED_MHZ),
      .DELAY_WIDTH     (DELAY_WIDTH)
    ) u_chan (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .start    (start[i]),
      .cancel   (cancel[i]),
      .periodic (periodic[i]),
      .delay_us (delay_us[i*DELAY_WIDTH +: DELAY_WIDTH]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer
//   Scoreboard bench for delay_timer (M=12, 4 channels, 16-bit delays).
//   A deadline-based reference model pushes the absolute cycle of every
//   expected done pulse into a per-channel queue; a monitor on the falling
//   edge compares done/busy against it.
module tb_delay_timer;

  localparam int M  = 12;
  localparam int CH = 4;
  localparam int DW = 16;

  logic             CLK;
  logic             RST_N;
  logic [CH-1:0]    start;
  logic [CH-1:0]    cancel;
  logic [CH-1:0]    periodic;
  logic [CH*DW-1:0] delay_us;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  // Reference model state, expressed as absolute deadlines.
  bit exp_active [CH];
  bit exp_per    [CH];
  int exp_dl     [CH];
  int next_fire  [CH];
  int exp_q      [CH][$];

  delay_timer #(
    .CLOCK_SPEED_MHZ (M),
    .CHANNELS        (CH),
    .DELAY_WIDTH     (DW)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .cancel   (cancel),
    .periodic (periodic),
    .delay_us (delay_us),
    .busy     (busy),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int ch, input logic [CH-1:0] act,
                             input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s ch=%0d cyc=%0d actual=%b expected=%b", name, ch, cyc, act, exp);
    end
  endtask

  // Reference model: a start with D schedules a pulse D*M edges later, a zero
  // delay fires on the start edge itself, cancel or retrigger drops whatever
  // was scheduled, and a periodic channel schedules its next pulse on firing.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < CH; c++) begin
        exp_active[c] = 0;
        exp_q[c].delete();
      end
    end else begin
      cyc++;
      for (int c = 0; c < CH; c++) begin
        int d;
        d = int'(delay_us[c*DW +: DW]);
        if (cancel[c]) begin
          exp_active[c] = 0;
          exp_q[c].delete();
        end else if (start[c]) begin
          exp_q[c].delete();
          if (d == 0) begin
            exp_active[c] = 0;
            exp_q[c].push_back(cyc);
          end else begin
            exp_active[c] = 1;
            exp_per[c]    = periodic[c];
            exp_dl[c]     = d;
            next_fire[c]  = cyc + d * M;
            exp_q[c].push_back(next_fire[c]);
          end
        end else if (exp_active[c] && cyc == next_fire[c]) begin
          if (exp_per[c]) begin
            next_fire[c] = next_fire[c] + exp_dl[c] * M;
            exp_q[c].push_back(next_fire[c]);
          end else begin
            exp_active[c] = 0;
          end
        end
      end
    end
  end

  // Monitor: after each edge, done must be high exactly when the head of the
  // channel queue names this cycle, and busy must follow the model.
  always @(negedge CLK) begin
    if (RST_N && mon_en) begin
      for (int c = 0; c < CH; c++) begin
        logic exp_d;
        exp_d = (exp_q[c].size() > 0) && (exp_q[c][0] == cyc);
        checkOutput("done", c, {{(CH-1){1'b0}}, done[c]}, {{(CH-1){1'b0}}, exp_d});
        checkOutput("busy", c, {{(CH-1){1'b0}}, busy[c]}, {{(CH-1){1'b0}}, exp_active[c]});
        while (exp_q[c].size() > 0 && exp_q[c][0] <= cyc) void'(exp_q[c].pop_front());
      end
    end
  end

  function automatic logic [CH*DW-1:0] slot(input int ch, input int d);
    logic [CH*DW-1:0] v;
    v = '0;
    v[ch*DW +: DW] = DW'(d);
    return v;
  endfunction

  // Called just after a falling edge: inputs are held across one rising edge,
  // then the pulse inputs are cleared.
  task automatic applyStimulus(input logic [CH-1:0] st, input logic [CH-1:0] cn,
                               input logic [CH-1:0] per, input logic [CH*DW-1:0] dv);
    start    = st;
    cancel   = cn;
    periodic = per;
    delay_us = dv;
    @(negedge CLK);
    start  = '0;
    cancel = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST_N    = 1'b0;
    start    = '0;
    cancel   = '0;
    periodic = '0;
    delay_us = '0;
    #12;
    checkOutput("reset_busy", -1, busy, '0);
    checkOutput("reset_done", -1, done, '0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    mon_en = 1;
    @(negedge CLK);

    $display("[TB] one-shot ch0 D=3");
    applyStimulus(4'b0001, 4'b0000, 4'b0000, slot(0, 3));
    idle(220);

    $display("[TB] zero delay ch2");
    applyStimulus(4'b0100, 4'b0000, 4'b0100, slot(2, 0));
    idle(10);

    $display("[TB] retrigger ch0 D=5 then D=2 at t0+20");
    applyStimulus(4'b0001, 4'b0000, 4'b0000, slot(0, 5));
    idle(19);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, slot(0, 2));
    idle(60);

    $display("[TB] periodic ch1 D=1, cancel at t0+30");
    applyStimulus(4'b0010, 4'b0000, 4'b0010, slot(1, 1));
    idle(29);
    applyStimulus(4'b0000, 4'b0010, 4'b0000, '0);
    idle(20);
    applyStimulus(4'b0010, 4'b0010, 4'b0010, slot(1, 1));
    idle(30);

    $display("[TB] reset mid-run ch0 D=2");
    applyStimulus(4'b0001, 4'b0000, 4'b0000, slot(0, 2));
    idle(9);
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    checkOutput("async_reset_busy", -1, busy, '0);
    checkOutput("async_reset_done", -1, done, '0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    idle(100);

    $display("[TB] independence ch1 D=2, ch3 D=1");
    applyStimulus(4'b1010, 4'b0000, 4'b0000, slot(1, 2) | slot(3, 1));
    idle(40);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 1500; k++) begin
      logic [CH-1:0]    st, cn, per;
      logic [CH*DW-1:0] dv;
      dv = '0;
      for (int c = 0; c < CH; c++) begin
        st[c]  = ($urandom_range(0, 24) == 0);
        cn[c]  = ($urandom_range(0, 59) == 0);
        per[c] = $urandom_range(0, 1) == 1;
        dv     = dv | slot(c, int'($urandom_range(0, 4)));
      end
      applyStimulus(st, cn, per, dv);
    end

    applyStimulus('0, {CH{1'b1}}, '0, '0);
    idle(5);
    for (int c = 0; c < CH; c++) begin
      checkOutput("queue_drained", c, CH'(exp_q[c].size()), '0);
    end

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
